wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Schedules the single regfile write port between two writeback sources: ALU (EX stage) and LSU (load data).
//  Each source gets a 1-entry holding buffer with valid/ready handshake. A fixed-priority arbiter with a
//  starvation guard and same-rd ordering drives the registered we/wa/wdata inputs of the regfile.
//  Sits between the EX/MEM stages and the regfile write port; optional scoreboard flags RAW hazards to decode.
// PARAMETERS
//  XLEN        32  data width of write data
//  STARVE_MAX  3   consecutive ALU losses tolerated before ALU is forced to win (1..7, 3-bit counter)
// PORTS
//  clk         in   1     clock, all state on rising edge
//  reset       in   1     asynchronous, active-low reset (0 = in reset)
//  alu_valid   in   1     ALU writeback request
//  alu_ready   out  1     ALU holding buffer can accept
//  alu_rd      in   5     ALU destination register
//  alu_data    in   XLEN  ALU result
//  lsu_valid   in   1     LSU writeback request
//  lsu_ready   out  1     LSU holding buffer can accept
//  lsu_rd      in   5     LSU destination register
//  lsu_data    in   XLEN  load data
//  rf_we       out  1     regfile write enable (registered)
//  rf_wa       out  5     regfile write address (registered)
//  rf_wdata    out  XLEN  regfile write data (registered)
//  iss_valid   in   1     instruction issued with destination iss_rd (scoreboard set)
//  iss_rd      in   5     destination of issued instruction
//  ra1, ra2    in   5     decode source registers for hazard query
//  hazard1/2   out  1     source register has a pending write (combinational)
// BEHAVIOUR
//  - Reset: both buffers empty, age flag 0, starvation counter 0, rf_we=0, rf_wa=0, rf_wdata=0, scoreboard clear.
//  - Handshake: transfer when valid && ready on a rising edge. ready = buffer empty OR buffer drained this cycle
//    (combinational from buffer state + grant; no dependency on the same source's valid).
//  - rd==0 request: handshake completes, data discarded, buffer not loaded, no write issued.
//  - Latency: request accepted at edge N -> rf_we=1 in cycle N+1 at earliest; regfile captures at edge N+2.
//    Sustained throughput 1 write/cycle total; each source can accept every cycle if it wins every cycle.
//  - Arbitration each cycle over valid buffers: only one valid -> it wins. Both valid:
//    a) same rd: older entry (age flag) wins, regardless of priority, preserving program order;
//    b) starve_cnt == STARVE_MAX: ALU wins;
//    c) otherwise LSU wins.
//  - Age flag: set to the source loaded first when the other buffer is empty; simultaneous load into two empty
//    buffers -> LSU marked older (load is the older instruction in the pipeline).
//  - starve_cnt: +1 when ALU buffer valid and LSU granted; cleared on ALU grant or ALU buffer empty; saturates.
//  - Output stage: every edge rf_we<=grant_any; rf_wa/rf_wdata<=winner's rd/data; hold previous values when
//    rf_we<=0. Winner's buffer frees on the same edge.
//  - Reset asserted mid-operation: buffered entries dropped, outputs to reset values immediately (async).
// CONFIGURATION
//  WB_SCOREBOARD_EN defined: 32-bit pending vector. iss_valid && iss_rd!=0 sets pending[iss_rd];
//   rf_we cycle clears pending[rf_wa]; set and clear of the same rd in one cycle -> set wins.
//   hazard1 = pending[ra1], hazard2 = pending[ra2]; ra==0 -> 0. Cleared only by reset or writeback.
//  WB_SCOREBOARD_EN undefined: no pending vector; iss_* ignored; hazard1/hazard2 tied 0. Ports unchanged.
// TESTING
//  1 Reset low 3 cycles then high, no requests -> rf_we=0, alu_ready=lsu_ready=1, hazards 0.
//  2 ALU rd=5 data=0x1234 at edge N -> rf_we=1, rf_wa=5, rf_wdata=0x1234 in cycle N+1 only.
//  3 ALU rd=3 and LSU rd=4 same edge -> LSU written first (cycle N+1), ALU next (N+2); alu_ready low in between.
//  4 LSU valid every cycle rd=1..8, ALU rd=9 held -> ALU wins after exactly 3 LSU grants; starve_cnt resets.
//  5 ALU rd=7 0xA accepted, next edge LSU rd=7 0xB while ALU still buffered -> writes 0xA then 0xB to x7.
//  6 (WB_SCOREBOARD_EN) iss rd=10 -> hazard1=1 with ra1=10; ALU writes rd=10 -> hazard1=0 cycle after rf_we;
//    iss rd=0 -> hazard stays 0; without macro hazard1/2 stay 0 throughout.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two 1-entry holding buffers (ALU, LSU) feeding one registered regfile write port.
// Optional RAW scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic            hazard1,
  output logic            hazard2
);

  localparam int unsigned CW        = 3;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  localparam logic [CW-1:0] STARVE_SAT = '1;

  logic            alu_v_q, alu_v_d;
  logic [4:0]      alu_rd_q, alu_rd_d;
  logic [XLEN-1:0] alu_data_q, alu_data_d;
  logic            lsu_v_q, lsu_v_d;
  logic [4:0]      lsu_rd_q, lsu_rd_d;
  logic [XLEN-1:0] lsu_data_q, lsu_data_d;
  logic            lsu_older_q, lsu_older_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_wa_q, rf_wa_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic alu_gnt, lsu_gnt, alu_load, lsu_load;

  // Grant: same-rd keeps program order, then starvation guard, then LSU priority.
  // The >= also covers the counter running past the limit while same-rd ordering held ALU off.
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (alu_v_q && lsu_v_q) begin
      if (alu_rd_q == lsu_rd_q) begin
        if (lsu_older_q) lsu_gnt = 1'b1;
        else             alu_gnt = 1'b1;
      end else if (starve_q >= STARVE_LIM) begin
        alu_gnt = 1'b1;
      end else begin
        lsu_gnt = 1'b1;
      end
    end else if (alu_v_q) begin
      alu_gnt = 1'b1;
    end else if (lsu_v_q) begin
      lsu_gnt = 1'b1;
    end
  end

  assign alu_ready = !alu_v_q || alu_gnt;
  assign lsu_ready = !lsu_v_q || lsu_gnt;
  assign alu_load  = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign lsu_load  = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

  always_comb begin
    alu_v_d     = alu_v_q && !alu_gnt;
    alu_rd_d    = alu_rd_q;
    alu_data_d  = alu_data_q;
    lsu_v_d     = lsu_v_q && !lsu_gnt;
    lsu_rd_d    = lsu_rd_q;
    lsu_data_d  = lsu_data_q;
    lsu_older_d = lsu_older_q;
    starve_d    = starve_q;
    rf_we_d     = alu_gnt || lsu_gnt;
    rf_wa_d     = rf_wa_q;
    rf_wdata_d  = rf_wdata_q;

    if (alu_load) begin
      alu_v_d    = 1'b1;
      alu_rd_d   = alu_rd;
      alu_data_d = alu_data;
    end
    if (lsu_load) begin
      lsu_v_d    = 1'b1;
      lsu_rd_d   = lsu_rd;
      lsu_data_d = lsu_data;
    end

    // A newly loaded entry is younger than whatever survives in the other buffer.
    if (alu_load && lsu_load)  lsu_older_d = 1'b1;
    else if (alu_load)         lsu_older_d = lsu_v_q && !lsu_gnt;
    else if (lsu_load)         lsu_older_d = !(alu_v_q && !alu_gnt);

    if (!alu_v_q || alu_gnt)                       starve_d = '0;
    else if (lsu_gnt && (starve_q != STARVE_SAT))  starve_d = starve_q + CW'(1);

    if (alu_gnt) begin
      rf_wa_d    = alu_rd_q;
      rf_wdata_d = alu_data_q;
    end else if (lsu_gnt) begin
      rf_wa_d    = lsu_rd_q;
      rf_wdata_d = lsu_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_v_q     <= 1'b0;
      alu_rd_q    <= '0;
      alu_data_q  <= '0;
      lsu_v_q     <= 1'b0;
      lsu_rd_q    <= '0;
      lsu_data_q  <= '0;
      lsu_older_q <= 1'b0;
      starve_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wdata_q  <= '0;
    end else begin
      alu_v_q     <= alu_v_d;
      alu_rd_q    <= alu_rd_d;
      alu_data_q  <= alu_data_d;
      lsu_v_q     <= lsu_v_d;
      lsu_rd_q    <= lsu_rd_d;
      lsu_data_q  <= lsu_data_d;
      lsu_older_q <= lsu_older_d;
      starve_q    <= starve_d;
      rf_we_q     <= rf_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending_q, pending_d;

  // Issue set is applied after writeback clear so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_wa_q] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) pending_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign hazard1 = (ra1 != 5'd0) && pending_q[ra1];
  assign hazard2 = (ra2 != 5'd0) && pending_q[ra2];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, ra1, ra2};
  assign hazard1   = 1'b0;
  assign hazard2   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: vector table plus reset corner sequences.
module tb_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid, iss_valid;
  logic        alu_ready, lsu_ready, rf_we, hazard1, hazard2;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, ra1, ra2, rf_wa;
  logic [31:0] alu_data, lsu_data, rf_wdata;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.XLEN(32), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .ra1(ra1), .ra2(ra2),
    .hazard1(hazard1), .hazard2(hazard2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  ra;
    logic        e_ardy;
    logic        e_lrdy;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_hz;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic iv, logic [4:0] ird, logic [4:0] ra,
                              logic ardy, logic lrdy, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic hz);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.ra = ra;
    v.e_ardy = ardy; v.e_lrdy = lrdy; v.e_we = we;
    v.e_wa = wa; v.e_wd = wd; v.e_hz = hz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    iss_valid = v.iv; iss_rd = v.ird; ra1 = v.ra; ra2 = v.ra;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
  endtask

  initial begin
    reset = 1'b0;
    idle();

    // ALU rd5 single write
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,0,0,32'h0,0));
    vq.push_back(mk(1,5,32'h1234, 0,0,0,        0,0,0,   1,1,0,0,32'h0,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,1,5,32'h1234,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,0,5,32'h1234,0));
    // simultaneous ALU rd3 / LSU rd4: LSU first
    vq.push_back(mk(1,3,32'h33,   1,4,32'h44,   0,0,0,   0,1,0,5,32'h1234,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,1,4,32'h44,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,1,3,32'h33,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,0,3,32'h33,0));
    // ALU x7=A then LSU x7=B
    vq.push_back(mk(1,7,32'hA,    0,0,0,        0,0,0,   1,1,0,3,32'h33,0));
    vq.push_back(mk(0,0,0,        1,7,32'hB,    0,0,0,   1,1,1,7,32'hA,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,1,7,32'hB,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,0,7,32'hB,0));
    // older ALU x3 beats younger LSU x3 despite LSU priority
    vq.push_back(mk(1,3,32'h31,   1,4,32'h41,   0,0,0,   0,1,0,7,32'hB,0));
    vq.push_back(mk(0,0,0,        1,3,32'h42,   0,0,0,   1,0,1,4,32'h41,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,1,3,32'h31,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,1,3,32'h42,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,0,3,32'h42,0));
    // starvation: ALU x9 wins after LSU x1,x2,x3
    vq.push_back(mk(1,9,32'h99,   1,1,32'h01,   0,0,0,   0,1,0,3,32'h42,0));
    vq.push_back(mk(0,0,0,        1,2,32'h02,   0,0,0,   0,1,1,1,32'h01,0));
    vq.push_back(mk(0,0,0,        1,3,32'h03,   0,0,0,   0,1,1,2,32'h02,0));
    vq.push_back(mk(0,0,0,        1,4,32'h04,   0,0,0,   1,0,1,3,32'h03,0));
    vq.push_back(mk(0,0,0,        1,5,32'h05,   0,0,0,   1,1,1,9,32'h99,0));
    vq.push_back(mk(0,0,0,        1,5,32'h05,   0,0,0,   1,1,1,4,32'h04,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,1,5,32'h05,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,0,5,32'h05,0));
    // rd0 requests are swallowed
    vq.push_back(mk(1,0,32'hDEAD, 1,0,32'hBEEF, 0,0,0,   1,1,0,5,32'h05,0));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,0,   1,1,0,5,32'h05,0));
    // scoreboard: set by issue, cleared after writeback
    vq.push_back(mk(0,0,0,        0,0,0,        1,10,10, 1,1,0,5,32'h05,1));
    vq.push_back(mk(1,10,32'h10,  0,0,0,        0,0,10,  1,1,0,5,32'h05,1));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,10,  1,1,1,10,32'h10,1));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,10,  1,1,0,10,32'h10,0));
    vq.push_back(mk(0,0,0,        0,0,0,        1,0,0,   1,1,0,10,32'h10,0));
    // re-issue coinciding with writeback clear: set wins
    vq.push_back(mk(0,0,0,        0,0,0,        1,11,11, 1,1,0,10,32'h10,1));
    vq.push_back(mk(1,11,32'h11,  0,0,0,        0,0,11,  1,1,0,10,32'h10,1));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,11,  1,1,1,11,32'h11,1));
    vq.push_back(mk(0,0,0,        0,0,0,        1,11,11, 1,1,0,11,32'h11,1));
    vq.push_back(mk(0,0,0,        0,0,0,        0,0,11,  1,1,0,11,32'h11,1));

    // reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",   32'(rf_we), 32'd0);
    chk("rst_wa",   32'(rf_wa), 32'd0);
    chk("rst_wd",   rf_wdata, 32'd0);
    chk("rst_ardy", 32'(alu_ready), 32'd1);
    chk("rst_lrdy", 32'(lsu_ready), 32'd1);
    chk("rst_hz",   32'({hazard1, hazard2}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ardy", i), 32'(alu_ready), 32'(vq[i].e_ardy));
      chk($sformatf("v%0d_lrdy", i), 32'(lsu_ready), 32'(vq[i].e_lrdy));
      chk($sformatf("v%0d_we", i),   32'(rf_we),     32'(vq[i].e_we));
      chk($sformatf("v%0d_wa", i),   32'(rf_wa),     32'(vq[i].e_wa));
      chk($sformatf("v%0d_wd", i),   rf_wdata,       vq[i].e_wd);
      chk($sformatf("v%0d_hz1", i),  32'(hazard1),   32'(vq[i].e_hz & SB));
      chk($sformatf("v%0d_hz2", i),  32'(hazard2),   32'(vq[i].e_hz & SB));
    end

    // async reset mid-operation with ALU still buffered and a write on the port
    drive(mk(1,6,32'h66, 1,8,32'h88, 0,0,11, 0,0,0,0,0,0));
    @(posedge clk);
    #1;
    drive(mk(0,0,0, 0,0,0, 0,0,11, 0,0,0,0,0,0));
    @(posedge clk);
    #1;
    chk("pre_rst_we",   32'(rf_we), 32'd1);
    chk("pre_rst_wa",   32'(rf_wa), 32'd8);
    chk("pre_rst_ardy", 32'(alu_ready), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_we", 32'(rf_we), 32'd0);
    chk("async_wa", 32'(rf_wa), 32'd0);
    chk("async_wd", rf_wdata, 32'd0);
    chk("async_hz", 32'(hazard1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_we",   32'(rf_we), 32'd0);
    chk("post_rst_wa",   32'(rf_wa), 32'd0);
    chk("post_rst_ardy", 32'(alu_ready), 32'd1);
    chk("post_rst_lrdy", 32'(lsu_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst2_we",  32'(rf_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
